// File: rtl/arm_fetch.sv
// ARM32 fetch stage: fetch PC, one-deep RAM read pipeline and prefetch FIFO toward decode.
// Optional misaligned-redirect fault is enabled by defining ARM_FETCH_ALIGN_CHECK_EN.
module arm_fetch #(
  parameter int ARCH       = 32,
  parameter int RAM_SIZE   = 4096,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(RAM_SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [ARCH-1:0] mem_rdata,
  output logic            ins_valid,
  output logic [ARCH-1:0] ins,
  output logic [ARCH-1:0] ins_pc,
  input  logic            ins_ready,
  input  logic            redirect_valid,
  input  logic [ARCH-1:0] redirect_pc,
  output logic            fetch_fault
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [ARCH-1:0] pc_reg;
  logic [ARCH-1:0] inflight_pc_reg;
  logic            inflight_reg;
  logic            fault_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [ARCH-1:0] ins_slot [FIFO_DEPTH];
  logic [ARCH-1:0] pc_slot  [FIFO_DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic            misalign;
  logic [OW-1:0]   occupancy;

  // Occupancy counts the outstanding read so a returning word always has a free slot.
  assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign issue     = !reset && !redirect_valid && !fault_reg && (occupancy < OW'(FIFO_DEPTH));
  assign push      = inflight_reg && !redirect_valid;
  assign pop       = ins_valid && ins_ready;

  assign mem_en    = issue;
  assign mem_addr  = pc_reg[AW+1:2];
  assign ins_valid = (count_reg != '0);
  assign ins       = ins_slot[rd_ptr_reg];
  assign ins_pc    = pc_slot[rd_ptr_reg];

`ifdef ARM_FETCH_ALIGN_CHECK_EN
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_reg;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misalign        = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [ARCH-1:0] ins_slot_reg;
      logic [ARCH-1:0] pc_slot_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          ins_slot_reg <= '0;
          pc_slot_reg  <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          ins_slot_reg <= mem_rdata;
          pc_slot_reg  <= inflight_pc_reg;
        end
      end

      assign ins_slot[gi] = ins_slot_reg;
      assign pc_slot[gi]  = pc_slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= '0;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      fault_reg       <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (redirect_valid) begin
      // Flush wins over push/pop; the read returning next cycle is dropped.
      pc_reg       <= {redirect_pc[ARCH-1:2], 2'b00};
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      if (misalign) begin
        fault_reg <= 1'b1;
      end
    end else begin
      if (issue) begin
        pc_reg          <= pc_reg + ARCH'(4);
        inflight_pc_reg <= pc_reg;
      end
      inflight_reg <= issue;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// Scoreboard bench for arm_fetch: expected PCs are queued when a fetch stream is started
// (reset release or redirect) and compared at every cycle the FIFO head is valid.
module tb_arm_fetch;
  localparam int ARCH       = 32;
  localparam int RAM_SIZE   = 4096;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(RAM_SIZE);
  localparam logic [31:0] IDX_MASK = 32'(RAM_SIZE - 1);
  localparam logic [31:0] WRAP_T   = 32'(4 * RAM_SIZE - 16);

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [ARCH-1:0] mem_rdata = '0;
  logic            ins_valid;
  logic [ARCH-1:0] ins;
  logic [ARCH-1:0] ins_pc;
  logic            ins_ready;
  logic            redirect_valid;
  logic [ARCH-1:0] redirect_pc;
  logic            fetch_fault;

  logic [31:0] ram [RAM_SIZE];
  logic [31:0] sb [$];
  int total = 0;
  int bad   = 0;

  arm_fetch #(.ARCH(ARCH), .RAM_SIZE(RAM_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .ins_valid(ins_valid),
    .ins(ins),
    .ins_pc(ins_pc),
    .ins_ready(ins_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) ram[i] = 32'hE280_0000 + 32'(i);
  end

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Head must match the scoreboard whenever valid, including while stalled.
  always @(negedge clk) begin : mon
    logic [31:0] exp_pc;
    if (!reset && ins_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_pc = sb[0];
        check("ins_pc", ins_pc, exp_pc);
        check("ins", ins, 32'hE280_0000 + ((exp_pc >> 2) & IDX_MASK));
        if (ins_ready) begin
          $display("xfer pc=%h ins=%h", ins_pc, ins);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    reset = 1'b1; ins_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    sample();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_ins_valid", 32'(ins_valid), 0);
    check("rst_ins", ins, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_fault", 32'(fetch_fault), 0);

    // Fetch latency and streaming
    tick(); reset = 1'b0; sb_load(0, 64);
    sample();
    check("lat_k_en", 32'(mem_en), 1);
    check("lat_k_addr", 32'(mem_addr), 0);
    check("lat_k_valid", 32'(ins_valid), 0);
    tick(); sample();
    check("lat_k1_valid", 32'(ins_valid), 0);
    check("lat_k1_addr", 32'(mem_addr), 1);
    tick(); sample();
    check("lat_k2_valid", 32'(ins_valid), 1);
    repeat (6) begin tick(); sample(); check("stream_valid", 32'(ins_valid), 1); end

    // Redirect with two buffered words and a read in flight
    tick(); ins_ready = 1'b0; sample();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; sample();
    check("redir_en", 32'(mem_en), 0);
    #1 sb_load(32'h100, 64);
    tick(); redirect_valid = 1'b0; ins_ready = 1'b1; sample();
    check("redir_r1_valid", 32'(ins_valid), 0);
    check("redir_r1_en", 32'(mem_en), 1);
    check("redir_r1_addr", 32'(mem_addr), 32'h40);
    tick(); sample();
    check("redir_r2_valid", 32'(ins_valid), 0);
    tick(); sample();
    check("redir_r3_valid", 32'(ins_valid), 1);
    check("redir_r3_pc", ins_pc, 32'h100);
    repeat (3) begin tick(); sample(); end

    // Back-to-back redirects: later target wins
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; sample();
    check("b2b_r_en", 32'(mem_en), 0);
    #1 sb_load(32'h200, 8);
    tick(); redirect_pc = 32'h300; sample();
    check("b2b_r1_valid", 32'(ins_valid), 0);
    check("b2b_r1_en", 32'(mem_en), 0);
    #1 sb_load(32'h300, 64);
    tick(); redirect_valid = 1'b0; sample();
    check("b2b_r2_valid", 32'(ins_valid), 0);
    check("b2b_r2_addr", 32'(mem_addr), 32'hC0);
    tick(); sample();
    check("b2b_r3_valid", 32'(ins_valid), 0);
    tick(); sample();
    check("b2b_r4_valid", 32'(ins_valid), 1);
    check("b2b_r4_pc", ins_pc, 32'h300);
    repeat (2) begin tick(); sample(); end

    // Address wraps at RAM_SIZE words while the PC keeps counting
    tick(); redirect_valid = 1'b1; redirect_pc = WRAP_T; sample();
    check("wrap_r_en", 32'(mem_en), 0);
    #1 sb_load(WRAP_T, 64);
    tick(); redirect_valid = 1'b0; sample();
    check("wrap_r1_addr", 32'(mem_addr), 32'(RAM_SIZE - 4));
    repeat (3) begin tick(); sample(); end
    tick(); sample();
    check("wrap_r5_en", 32'(mem_en), 1);
    check("wrap_r5_addr", 32'(mem_addr), 0);
    tick(); sample();
    tick(); sample();
    check("wrap_pc", ins_pc, 32'(4 * RAM_SIZE));
    check("wrap_ins", ins, 32'hE280_0000);
    repeat (2) begin tick(); sample(); end

    // Reset with three entries buffered and a read in flight, then back-pressure
    tick(); ins_ready = 1'b0; sample();
    tick(); sample();
    tick(); reset = 1'b1; sample();
    check("mid_rst_en", 32'(mem_en), 0);
    #1 sb_load(0, 64);
    tick(); reset = 1'b0; sample();
    check("mid_rst_valid", 32'(ins_valid), 0);
    check("mid_rst_ins", ins, 0);
    check("mid_rst_pc", ins_pc, 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_en1", 32'(mem_en), 1);
    n_iss = int'(mem_en);
    repeat (9) begin tick(); sample(); n_iss += int'(mem_en); end
    check("bp_issues", 32'(n_iss), 4);
    check("bp_stall", 32'(mem_en), 0);
    tick(); ins_ready = 1'b1; sample();
    check("bp_release_en", 32'(mem_en), 0);
    tick(); sample();
    check("bp_resume_en", 32'(mem_en), 1);
    check("bp_resume_addr", 32'(mem_addr), 4);
    repeat (8) begin tick(); sample(); end

    // Misaligned redirect
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h102; sample();
    check("mis_r_en", 32'(mem_en), 0);
    #1 sb_load(32'h100, 64);
    tick(); redirect_valid = 1'b0; sample();
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin tick(); sample(); end
      check("mis_fault", 32'(fetch_fault), 1);
      check("mis_en", 32'(mem_en), 0);
      check("mis_valid", 32'(ins_valid), 0);
    end
    tick(); reset = 1'b1; sample();
    #1 sb_load(0, 64);
    tick(); reset = 1'b0; sample();
    check("mis_clr_fault", 32'(fetch_fault), 0);
    check("mis_clr_en", 32'(mem_en), 1);
    check("mis_clr_addr", 32'(mem_addr), 0);
    tick(); tick(); sample();
    check("mis_clr_valid", 32'(ins_valid), 1);
    check("mis_clr_pc", ins_pc, 0);
`else
    check("mis_fault", 32'(fetch_fault), 0);
    check("mis_en", 32'(mem_en), 1);
    check("mis_addr", 32'(mem_addr), 32'h40);
    tick(); sample();
    check("mis_r2_valid", 32'(ins_valid), 0);
    tick(); sample();
    check("mis_r3_valid", 32'(ins_valid), 1);
    check("mis_r3_pc", ins_pc, 32'h100);
    check("mis_r3_fault", 32'(fetch_fault), 0);
`endif
    repeat (2) begin tick(); sample(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_fetch.md
# arm_fetch

Instruction fetch stage of the ARM32 core, directly upstream of the processor's decode/execute stage. It holds the fetch PC and issues word reads to the synchronous instruction RAM. Returned words go into a small prefetch FIFO, which presents `{ins, ins_pc}` to decode through a valid/ready handshake. Decode can redirect the PC (branch, exception); a redirect flushes the FIFO and any read still in flight.

## Interface
- `ARCH`, 32: data and PC width.
- `RAM_SIZE`, 4096: RAM depth in words; `AW = $clog2(RAM_SIZE)`.
- `FIFO_DEPTH`, 4: prefetch entries; must be a power of 2 and at least 2.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_en` out 1: read request to the RAM this cycle.
- `mem_addr` out AW: word address, equal to `pc[AW+1:2]`.
- `mem_rdata` in ARCH: read data, valid the cycle after `mem_en`.
- `ins_valid` out 1: FIFO head holds a valid instruction.
- `ins` out ARCH: instruction word at the FIFO head.
- `ins_pc` out ARCH: byte address of `ins`.
- `ins_ready` in 1: decode accepts the head entry this cycle.
- `redirect_valid` in 1: load a new fetch PC.
- `redirect_pc` in ARCH: target byte address.
- `fetch_fault` out 1: misaligned redirect (see Configuration).

## Operation
- State:
  - `pc` (ARCH): fetch PC.
  - `inflight` (1 bit): read outstanding.
  - `inflight_pc`: PC of the outstanding read.
  - FIFO: `FIFO_DEPTH` x {ins, pc}, with read and write pointers and a count.
  - `fault` (sticky).
- Issue rule:
  - `mem_en = !reset && !redirect_valid && !fault && (count + inflight < FIFO_DEPTH)`.
  - No combinational path from `ins_ready` to `mem_en`.
- On issue:
  - `inflight <= 1`, `inflight_pc <= pc`.
  - `pc <= pc + 4`, modulo 2^ARCH. `mem_addr` therefore wraps at `RAM_SIZE` words.
- Cycle after an issue: `mem_rdata` and `inflight_pc` are pushed into the FIFO. `inflight` clears unless a new issue occurs in the same cycle.
- Pop: when `ins_valid && ins_ready`, the read pointer advances. Push and pop may happen in the same cycle; the count is then unchanged.
- `ins` and `ins_pc` are driven combinationally from the FIFO head entry.
- FIFO full: no issue, `pc` held. The issue rule guarantees the FIFO never overflows.
- Redirect (`redirect_valid = 1` in cycle r):
  - A pop handshake in cycle r still completes; decode owns that word.
  - At the end of cycle r:
    - FIFO count = 0, pointers reset.
    - `pc <= {redirect_pc[ARCH-1:2], 2'b00}`.
    - `inflight` cleared. The RAM response arriving in r+1 is discarded.
  - Redirect has priority over push and pop.
- Reset: every register cleared, in-flight read dropped, takes effect at any point in operation.
  - `pc = 0`, `inflight = 0`, FIFO storage, count and pointers = 0.
  - Outputs: `fault = 0`, `mem_en = 0`, `mem_addr = 0`, `ins_valid = 0`, `ins = 0`, `ins_pc = 0`.

## Timing
- Fetch latency: first cycle k with `reset` low → `mem_en = 1`, `mem_addr = 0` in k; data in k+1; `ins_valid = 1` in k+2.
- Steady state with `ins_ready` held at 1: one instruction per cycle. `count + inflight` stays at or below 2, so the FIFO never stalls.
- Redirect in cycle r:
  - `mem_en = 0` in r; `ins_valid = 0` in r+1.
  - First new request in r+1; first redirected instruction valid in r+3.
- Back-to-back redirects in r and r+1: the later one wins; its target is valid in r+4.
- `ins` and `ins_pc` must hold stable while `ins_valid && !ins_ready`.

## Configuration
- Macro `ARM_FETCH_ALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_pc[1:0] != 0` does the following at the end of that cycle:
  - Sets `fault` (sticky until `reset`); FIFO is flushed and the in-flight read dropped.
  - `mem_en` stays 0 and `ins_valid` stays 0 until reset.
  - `fetch_fault` mirrors `fault`.
- Undefined: `redirect_pc[1:0]` is ignored (forced to 00) and `fetch_fault` is tied to 0.

## Test plan
- RAM preloaded with word[i] = 0xE280_0000 + i; release reset with `ins_ready` = 1 → `ins_valid` rises in k+2; `ins` = 0xE2800000, 0xE2800001, … on consecutive cycles; `ins_pc` = 0, 4, 8, ….
- Hold `ins_ready` = 0 for 10 cycles → at most `FIFO_DEPTH` = 4 issues, then `mem_en` = 0 and `ins`/`ins_pc` stable. Raise `ins_ready` → words 0..3 delivered in order, then fetching resumes at pc 0x10.
- Redirect to 0x100 while the FIFO holds pc 0x8 and 0xC and a read is in flight → the in-flight word is never delivered; next valid `ins_pc` = 0x100, arriving 3 cycles after the redirect.
- Run to `pc` = 4*RAM_SIZE − 4 → next `mem_addr` = 0 and `ins_pc` = 4*RAM_SIZE, i.e. the PC is not wrapped but the address is.
- Assert `reset` for 1 cycle with 3 entries buffered and a read in flight → all outputs and state return to their reset values; fetch restarts at pc 0.
- Redirect to 0x102:
  - with the macro defined → `fetch_fault` = 1, `ins_valid` and `mem_en` stay 0 until reset;
  - without it → next `ins_pc` = 0x100, `fetch_fault` = 0.
